// File: rtl/fifo_tb_pkg.sv
// Shared types and constants for the FIFO stimulus driver and its LFSR.
package fifo_tb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drv_state_t;

  localparam logic [1:0] MODE_FILL  = 2'd0;
  localparam logic [1:0] MODE_RAND  = 2'd1;
  localparam logic [1:0] MODE_PROBE = 2'd2;
  localparam logic [1:0] MODE_SIM   = 2'd3;

  // x^16+x^14+x^13+x^11+1 in right-shift form: feedback taken from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/fifo_lfsr16.sv
// 16-bit Fibonacci LFSR that advances only while enabled; reset loads the seed.
module fifo_lfsr16
  import fifo_tb_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (en_i) state_d = {^(state_q & LFSR_TAPS), state_q[15:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SEED;
    else        state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/fifo_stim_driver.sv
// Self-checking FIFO traffic initiator: issues registered wr/rd requests, tracks a shadow
// occupancy, and counts flag and read-data mismatches against its own sequence model.
module fifo_stim_driver
  import fifo_tb_pkg::*;
#(
  parameter int          DATA_W  = 8,
  parameter int          DEPTH   = 4,
  parameter logic [15:0] LFSR_SD = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [15:0]       num_ops,
  input  logic              full,
  input  logic              empty,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic              rd_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_count,
  output logic [15:0]       ops_done
);

  localparam int             OCC_W   = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

  drv_state_t        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [15:0]       num_q, num_d;
  logic [15:0]       ops_q, ops_d;
  logic [15:0]       err_q, err_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [DATA_W-1:0] wr_seq_q, wr_seq_d;
  logic [DATA_W-1:0] rd_seq_q, rd_seq_d;
  logic              fill_q, fill_d;
  logic              prb_wr_q, prb_wr_d;
  logic              prb_rd_q, prb_rd_d;
  logic              rd_acc_q, rd_acc_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              wr_acc, rd_acc, flag_err, data_err;
  logic              at_full, at_empty;
  logic [1:0]        req_mode;
  logic              req_fill, req_pw, req_pr;
  logic              req_wr, req_rd, fill_n, prb_wr_n, prb_rd_n;
  logic [15:0]       lfsr;
  logic              lfsr_unused;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  fifo_lfsr16 #(.SEED(LFSR_SD)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q == RUN),
    .state_o(lfsr)
  );
  assign lfsr_unused = ^lfsr[15:1];

  assign wr_acc   = wr_en_q && !full;
  assign rd_acc   = rd_en_q && !empty;
  assign flag_err = busy_q && ((full != (occ_q == OCC_MAX)) || (empty != (occ_q == '0)));
  assign data_err = rd_acc_q && (rd_data != rd_seq_q);

  // Shadow occupancy saturates at both ends so a misbehaving FIFO cannot wrap it.
  always_comb begin
    occ_d = occ_q;
    if (wr_acc && !rd_acc && occ_q != OCC_MAX)   occ_d = occ_q + OCC_W'(1);
    else if (rd_acc && !wr_acc && occ_q != '0)   occ_d = occ_q - OCC_W'(1);
  end

  assign at_full  = (occ_d == OCC_MAX);
  assign at_empty = (occ_d == '0);

  // Next request is planned from the post-edge occupancy; from IDLE the start values apply.
  always_comb begin
    req_mode = (state_q == IDLE) ? mode : mode_q;
    req_fill = (state_q == IDLE) ? 1'b1 : fill_q;
    req_pw   = (state_q == IDLE) ? 1'b0 : prb_wr_q;
    req_pr   = (state_q == IDLE) ? 1'b0 : prb_rd_q;
    fill_n   = req_fill;
    prb_wr_n = req_pw;
    prb_rd_n = req_pr;
    req_wr   = 1'b0;
    req_rd   = 1'b0;
    if (req_fill && at_full)        fill_n = 1'b0;
    else if (!req_fill && at_empty) fill_n = 1'b1;
    case (req_mode)
      MODE_RAND: begin
        req_wr = lfsr[0] && !at_full;
        req_rd = !lfsr[0] && !at_empty;
      end
      MODE_SIM: begin
        req_wr = !at_full;
        req_rd = !at_empty;
      end
      default: begin
        req_wr = fill_n;
        req_rd = !fill_n;
        if (req_mode == MODE_PROBE) begin
          if (at_full && !req_pw) begin
            req_wr   = 1'b1;
            req_rd   = 1'b0;
            prb_wr_n = 1'b1;
          end else if (at_empty && !req_pr) begin
            req_wr   = 1'b0;
            req_rd   = 1'b1;
            prb_rd_n = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    num_d    = num_q;
    ops_d    = ops_q;
    fill_d   = fill_q;
    prb_wr_d = prb_wr_q;
    prb_rd_d = prb_rd_q;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    rd_acc_d = rd_acc;
    wr_seq_d = wr_seq_q + DATA_W'(wr_acc);
    rd_seq_d = rd_seq_q + DATA_W'(rd_acc_q);
    err_d    = sat_add(err_q, 2'(flag_err) + 2'(data_err));
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d   = mode;
          num_d    = num_ops;
          ops_d    = '0;
          err_d    = '0;
          wr_seq_d = '0;
          rd_seq_d = '0;
          if (num_ops == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = RUN;
            busy_d   = 1'b1;
            wr_en_d  = req_wr;
            rd_en_d  = req_rd;
            fill_d   = fill_n;
            prb_wr_d = prb_wr_n;
            prb_rd_d = prb_rd_n;
          end
        end
      end
      RUN: begin
        busy_d = 1'b1;
        ops_d  = ops_q + 16'(wr_acc || rd_acc);
        if (ops_d == num_q) begin
          state_d = FLUSH;
          rd_en_d = !at_empty;
        end else begin
          wr_en_d  = req_wr;
          rd_en_d  = req_rd;
          fill_d   = fill_n;
          prb_wr_d = prb_wr_n;
          prb_rd_d = prb_rd_n;
        end
      end
      FLUSH: begin
        if (at_empty) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
          rd_en_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= '0;
      num_q    <= '0;
      ops_q    <= '0;
      err_q    <= '0;
      occ_q    <= '0;
      wr_seq_q <= '0;
      rd_seq_q <= '0;
      fill_q   <= 1'b1;
      prb_wr_q <= 1'b0;
      prb_rd_q <= 1'b0;
      rd_acc_q <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      num_q    <= num_d;
      ops_q    <= ops_d;
      err_q    <= err_d;
      occ_q    <= occ_d;
      wr_seq_q <= wr_seq_d;
      rd_seq_q <= rd_seq_d;
      fill_q   <= fill_d;
      prb_wr_q <= prb_wr_d;
      prb_rd_q <= prb_rd_d;
      rd_acc_q <= rd_acc_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign wr_data   = wr_seq_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_count = err_q;
  assign ops_done  = ops_q;

endmodule

// File: tb/tb_fifo_stim_driver.sv
// Bench for fifo_stim_driver: a 4-deep behavioural FIFO (with an empty-stuck-low fault option)
// and a write/read scoreboard, driven by a linear sequence of directed runs.
`timescale 1ns/1ps
module tb_fifo_stim_driver;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [15:0]       num_ops = 16'd0;
  logic              full, empty;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en, rd_en;
  logic [DATA_W-1:0] wr_data;
  logic              busy, done;
  logic [15:0]       err_count, ops_done;

  always #5 clk = ~clk;

  fifo_stim_driver #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LFSR_SD(16'hACE1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .num_ops  (num_ops),
    .full     (full),
    .empty    (empty),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err_count(err_count),
    .ops_done (ops_done)
  );

  // Behavioural FIFO
  logic [DATA_W-1:0] mem [DEPTH];
  logic [1:0]        wp, rp;
  logic [2:0]        f_cnt;
  logic              f_wok, f_rok;
  logic              empty_stuck0 = 1'b0;

  assign f_wok = wr_en && (f_cnt != 3'(DEPTH));
  assign f_rok = rd_en && (f_cnt != 3'd0);
  assign full  = (f_cnt == 3'(DEPTH));
  assign empty = (f_cnt == 3'd0) && !empty_stuck0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp      <= 2'd0;
      rp      <= 2'd0;
      f_cnt   <= 3'd0;
      rd_data <= '0;
    end else begin
      if (f_wok) begin
        mem[wp] <= wr_data;
        wp      <= wp + 2'd1;
      end
      if (f_rok) begin
        rd_data <= mem[rp];
        rp      <= rp + 2'd1;
      end
      f_cnt <= f_cnt + 3'(f_wok) - 3'(f_rok);
    end
  end

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and traffic statistics, sampled on the falling edge
  logic [DATA_W-1:0] sb_q [$];
  logic [DATA_W-1:0] exp_wr = '0;
  logic              rd_pend = 1'b0;
  logic              busy_prev = 1'b0;
  int n_wr = 0, n_rd = 0, n_sim = 0, wr_full = 0, rd_empty = 0, max_cnt = 0, flag0_cyc = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        rd_pend   = 1'b0;
        busy_prev = 1'b0;
      end else begin
        if (rd_pend) begin
          chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) chk("rd_order", 32'(rd_data), 32'(sb_q.pop_front()));
        end
        rd_pend = 1'b0;
        if (busy && !busy_prev) begin
          exp_wr = '0; n_wr = 0; n_rd = 0; n_sim = 0;
          wr_full = 0; rd_empty = 0; max_cnt = 0; flag0_cyc = 0;
        end
        busy_prev = busy;
        if (busy && f_cnt == 3'd0) flag0_cyc++;
        if (wr_en && full) wr_full++;
        if (rd_en && empty) rd_empty++;
        if (int'(f_cnt) > max_cnt) max_cnt = int'(f_cnt);
        if (f_wok) begin
          chk("wr_data", 32'(wr_data), 32'(exp_wr));
          sb_q.push_back(exp_wr);
          exp_wr = exp_wr + 1'b1;
          n_wr++;
        end
        if (f_rok) begin
          rd_pend = 1'b1;
          n_rd++;
        end
        if (f_wok && f_rok) n_sim++;
      end
    end
  end

  task automatic run_op(input string tag, input logic [1:0] m, input logic [15:0] n,
                        input int budget, input bit glitch);
    int cyc;
    @(negedge clk);
    mode = m; num_ops = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (n != 16'd0) chk({tag, "_busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = glitch && (cyc == 3);
      if (start) begin
        mode    = 2'd3;
        num_ops = 16'd2;
      end
    end
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_ops"}, 32'(ops_done), 32'(n));
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err_count), 32'd0);
    chk({tag, "_ops"}, 32'(ops_done), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fill/drain: 4 writes to full, 4 reads back in order
    run_op("t1", 2'd0, 16'd8, 200, 1'b0);
    chk("t1_err", 32'(err_count), 32'd0);
    chk("t1_writes", 32'(n_wr), 32'd4);
    chk("t1_reads", 32'(n_rd), 32'd4);
    chk("t1_full_seen", 32'(max_cnt), 32'd4);
    chk("t1_sb_drained", 32'(sb_q.size()), 32'd0);

    // Probe: one rejected read while empty and one rejected write while full
    run_op("t2", 2'd2, 16'd8, 200, 1'b0);
    chk("t2_err", 32'(err_count), 32'd0);
    chk("t2_wr_full", 32'(wr_full), 32'd1);
    chk("t2_rd_empty", 32'(rd_empty), 32'd1);
    chk("t2_max_occ", 32'(max_cnt <= DEPTH), 32'd1);
    chk("t2_writes", 32'(n_wr), 32'd4);

    // Simultaneous: one lone write, then 19 combined ops at occupancy 1
    run_op("t3", 2'd3, 16'd20, 200, 1'b0);
    chk("t3_err", 32'(err_count), 32'd0);
    chk("t3_sim", 32'(n_sim), 32'd19);
    chk("t3_max_occ", 32'(max_cnt), 32'd1);
    chk("t3_reads", 32'(n_rd), 32'd20);

    // Faulty FIFO: empty stuck low flags every busy cycle at zero occupancy
    empty_stuck0 = 1'b1;
    run_op("t4", 2'd0, 16'd8, 200, 1'b0);
    chk("t4_err", 32'(err_count), 32'(flag0_cyc));
    chk("t4_flag_cycles", 32'(flag0_cyc), 32'd2);
    empty_stuck0 = 1'b0;
    repeat (2) @(negedge clk);

    // Random traffic long enough to wrap the 8-bit sequence
    run_op("t5", 2'd1, 16'd1000, 10000, 1'b0);
    chk("t5_err", 32'(err_count), 32'd0);
    chk("t5_wrapped", 32'(n_wr > 256), 32'd1);

    // Start pulse while busy is ignored
    run_op("t7", 2'd0, 16'd8, 200, 1'b1);
    chk("t7_err", 32'(err_count), 32'd0);
    chk("t7_writes", 32'(n_wr), 32'd4);

    // Zero operations go straight to DONE
    run_op("t8", 2'd0, 16'd0, 20, 1'b0);
    chk("t8_err", 32'(err_count), 32'd0);

    // Mid-run reset aborts at once without a done pulse
    @(negedge clk);
    mode = 2'd0; num_ops = 16'd1000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_running", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("t6_abort");
    repeat (2) begin
      @(negedge clk);
      chk("t6_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_op("t6", 2'd0, 16'd8, 200, 1'b0);
    chk("t6_err", 32'(err_count), 32'd0);
    chk("t6_writes", 32'(n_wr), 32'd4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
